// File: rtl/opti_sample_feeder_if.sv
// Sample stream bundle: upstream valid/ready push side and the paced strobe toward the biquad.
interface opti_sample_feeder_if #(
    parameter int DATA_W = 24
);
    logic signed [DATA_W-1:0] s_data;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] m_data;
    logic                     m_valid;

    modport master (output s_data, s_valid, input s_ready, m_data, m_valid);
    modport slave  (input s_data, s_valid, output s_ready, m_data, m_valid);
endinterface

// File: rtl/opti_sample_feeder.sv
// Biquad input feeder: FIFO buffering, rounding pre-shift, saturation to the section
// range and GAP-paced single-cycle strobes.
module opti_sample_feeder #(
    parameter int DEPTH  = 8,
    parameter int GAP    = 4,
    parameter int DATA_W = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     enable,
    input  logic [2:0]               cfg_shift,
    opti_sample_feeder_if.slave      bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sat_flag
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic signed [DATA_W:0] SAT_MAX = (DATA_W+1)'((1 <<< (DATA_W-2)) - 1);
    localparam logic signed [DATA_W:0] SAT_MIN = (DATA_W+1)'(-(1 <<< (DATA_W-2)));

    function automatic logic signed [DATA_W:0] round_shift(
        input logic signed [DATA_W-1:0] x,
        input logic [2:0]               s
    );
        logic signed [DATA_W:0] ext;
        logic signed [DATA_W:0] bias;
        ext  = {x[DATA_W-1], x};
        bias = '0;
        if (s != 3'd0)
            bias[s - 3'd1] = 1'b1;
        return (ext + bias) >>> s;
    endfunction

    function automatic logic is_sat(input logic signed [DATA_W:0] y);
        return (y > SAT_MAX) || (y < SAT_MIN);
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [DATA_W:0] y);
        if (y > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        if (y < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        return y[DATA_W-1:0];
    endfunction

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              count;
    logic [PW-1:0]            pacer;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop_p0;
    logic signed [DATA_W:0]   y_p0;
    logic signed [DATA_W-1:0] m_data_p1;
    logic                     vld_p1;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    // s_ready comes from the registered count, so a full FIFO refuses even when popping.
    assign push   = bus.s_valid && !full && !flush;
    assign pop_p0 = enable && !empty && (pacer == '0) && !flush;

    assign bus.s_ready = !full;
    assign level       = count;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.s_data;
    end

    // Stage p0: FIFO head read and scaling
    assign y_p0 = round_shift(mem[rd_ptr], cfg_shift);

    // Stage p1: registered strobe and saturated sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pacer     <= '0;
            vld_p1    <= 1'b0;
            m_data_p1 <= '0;
            sat_flag  <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pacer    <= '0;
            vld_p1   <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            vld_p1 <= pop_p0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_p0)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop_p0)
                count <= count + 1'b1;
            else if (!push && pop_p0)
                count <= count - 1'b1;
            if (pop_p0)
                pacer <= PW'(GAP - 1);
            else if (pacer != '0)
                pacer <= pacer - 1'b1;
            if (pop_p0) begin
                m_data_p1 <= saturate(y_p0);
                if (is_sat(y_p0))
                    sat_flag <= 1'b1;
            end
        end
    end

    assign bus.m_data  = m_data_p1;
    assign bus.m_valid = vld_p1;
endmodule

// File: tb/tb_opti_sample_feeder.sv
// Directed bench for opti_sample_feeder with a queue scoreboard and a negedge monitor.
module tb_opti_sample_feeder;
    localparam int DEPTH = 8;
    localparam int GAP   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] cfg_shift = 3'd0;
    logic [$clog2(DEPTH):0] level;
    logic       sat_flag;

    opti_sample_feeder_if #(.DATA_W(24)) bus ();

    opti_sample_feeder #(.DEPTH(DEPTH), .GAP(GAP), .DATA_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .enable(enable),
        .cfg_shift(cfg_shift), .bus(bus), .level(level), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    int cyc = 0;
    int last_t = -1;
    int last_spacing = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n && bus.m_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: got m_data %0d expected no strobe", int'(bus.m_data));
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(bus.m_data) != e) begin
                    bad++;
                    $display("FAIL m_data: got %0d expected %0d", int'(bus.m_data), e);
                end
            end
            if (last_t >= 0) begin
                total++;
                last_spacing = cyc - last_t;
                if (last_spacing < GAP) begin
                    bad++;
                    $display("FAIL strobe_gap: got %0d expected >= %0d", last_spacing, GAP);
                end
            end
            last_t = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int x, input int e);
        int n;
        n = 0;
        bus.s_data  = 24'(x);
        bus.s_valid = 1'b1;
        while (!bus.s_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            chk("push_timeout", n, 0);
        end else begin
            exp_q.push_back(e);
            step();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            step();
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
        step();
    endtask

    initial begin
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        #12;
        chk("rst_level", int'(level), 0);
        chk("rst_s_ready", int'(bus.s_ready), 1);
        chk("rst_m_valid", int'(bus.m_valid), 0);
        chk("rst_m_data", int'(bus.m_data), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
        rst_n = 1'b1;
        step();

        // 1: back-to-back pushes, strobes exactly GAP apart
        enable = 1'b1;
        push(100, 100);
        push(-200, -200);
        push(300, 300);
        drain();
        chk("t1_spacing", last_spacing, GAP);
        chk("t1_level", int'(level), 0);

        // 2: fill while held, ninth word waits for space
        enable = 1'b0;
        for (int i = 1; i <= 8; i++) push(i * 11, i * 11);
        chk("t2_level_full", int'(level), 8);
        chk("t2_s_ready_full", int'(bus.s_ready), 0);
        step();
        step();
        chk("t2_level_hold", int'(level), 8);
        enable = 1'b1;
        push(99, 99);
        drain();
        chk("t2_level_end", int'(level), 0);

        // 3: rounding shifts
        cfg_shift = 3'd2;
        push(5, 1);
        push(6, 2);
        push(-5, -1);
        push(-6, -1);
        drain();
        cfg_shift = 3'd7;
        push(64, 1);
        push(63, 0);
        push(-64, 0);
        push(-65, -1);
        push(-8388608, -65536);
        drain();
        chk("t3_sat_flag", int'(sat_flag), 0);

        // 4: saturation and sticky flag
        cfg_shift = 3'd0;
        push(4194303, 4194303);
        drain();
        chk("t4_sat_edge", int'(sat_flag), 0);
        push(8388607, 4194303);
        drain();
        chk("t4_sat_pos", int'(sat_flag), 1);
        cfg_shift = 3'd1;
        push(8388607, 4194303);
        drain();
        cfg_shift = 3'd0;
        push(-8388608, -4194304);
        push(-4194304, -4194304);
        drain();
        chk("t4_sat_sticky", int'(sat_flag), 1);

        // 5: flush with 5 words queued and a simultaneous push
        enable = 1'b0;
        for (int i = 0; i < 5; i++) push(1000 + i, 1000 + i);
        chk("t5_level_pre", int'(level), 5);
        flush       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 24'(77);
        step();
        flush       = 1'b0;
        bus.s_valid = 1'b0;
        exp_q.delete();
        last_t = -1;
        chk("t5_level", int'(level), 0);
        chk("t5_sat_flag", int'(sat_flag), 0);
        chk("t5_s_ready", int'(bus.s_ready), 1);
        chk("t5_m_data_hold", int'(bus.m_data), -4194304);
        enable = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("t5_level_idle", int'(level), 0);
        push(7, 7);
        drain();

        // 6: async reset mid-stream
        enable = 1'b0;
        push(21, 21);
        push(22, 22);
        push(23, 23);
        chk("t6_level_pre", int'(level), 3);
        enable = 1'b1;
        step();
        chk("t6_m_valid_pre", int'(bus.m_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_m_valid", int'(bus.m_valid), 0);
        chk("t6_level", int'(level), 0);
        chk("t6_s_ready", int'(bus.s_ready), 1);
        chk("t6_m_data", int'(bus.m_data), 0);
        exp_q.delete();
        last_t = -1;
        step();
        rst_n = 1'b1;
        step();
        push(42, 42);
        push(43, 43);
        drain();
        chk("final_level", int'(level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
